// File: rtl/registro_pipe.sv
// registro_pipe: elastic register pipeline with valid/ready handshakes.
// Bubbles collapse forward; flush drops contents, reset restores RESET_VAL.
module registro_pipe #(
  parameter int N = 16,
  parameter int STAGES = 3,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [N-1:0]                     in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [N-1:0]                     out_data,
  output logic [$clog2(STAGES+1)-1:0]      occupancy
);

  localparam int OW = $clog2(STAGES + 1);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] fill;
  logic [STAGES-1:0] v_nxt;
  logic [N-1:0]      d   [STAGES];
  logic [N-1:0]      din [STAGES];

  // Advance chain: a stage frees up when its successor is empty or moving.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = v[k] & (~v[k+1] | adv[k+1]);
    end
  end

  assign in_ready = ~reset & ~flush & (~v[0] | adv[0]);

  // Per-stage load strobes, incoming data and next valid bits.
  always_comb begin
    fill    = '0;
    fill[0] = in_valid & in_ready;
    din[0]  = in_data;
    for (int k = 1; k < STAGES; k++) begin
      fill[k] = adv[k-1];
      din[k]  = d[k-1];
    end
    v_nxt = (v & ~adv) | fill;
  end

  // Population count of the valid bits.
  always_comb begin
    occupancy = '0;
    for (int k = 0; k < STAGES; k++) begin
      occupancy = occupancy + OW'(v[k]);
    end
  end

  // State update; data registers only move when a word is loaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
      for (int k = 0; k < STAGES; k++) begin
        d[k] <= RESET_VAL;
      end
    end else begin
      v <= flush ? '0 : v_nxt;
      for (int k = 0; k < STAGES; k++) begin
        if (fill[k] & ~flush) begin
          d[k] <= din[k];
        end
      end
    end
  end

  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];

endmodule
